// File: rtl/fifo_param_flags.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_param_flags
//  Brief    : Parametrised synchronous FIFO with occupancy level, programmable
//             almost-full/almost-empty, sticky overflow/underflow flags and an
//             optional first-word-fall-through read (macro FIFO_FWFT_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_param_flags #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr_err,
    input  logic [DATA_W-1:0]        data_in,
    output logic [DATA_W-1:0]        data_out,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] c_depth = PW'(DEPTH);
    localparam logic [PW-1:0] c_af    = PW'(AF_THRESH);
    localparam logic [PW-1:0] c_ae    = PW'(AE_THRESH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_level;
    logic              r_overflow;
    logic              r_underflow;

    logic [AW-1:0]     w_wr_addr;
    logic [AW-1:0]     w_rd_addr;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_ok;
    logic              w_rd_ok;
    // Wrap bits are carried for pointer bookkeeping; flags come from the level.
    logic              w_unused_wrap;

    assign w_wr_addr     = r_wr_ptr[AW-1:0];
    assign w_rd_addr     = r_rd_ptr[AW-1:0];
    assign w_unused_wrap = r_wr_ptr[AW] ^ r_rd_ptr[AW];

    assign w_full  = (r_level == c_depth);
    assign w_empty = (r_level == '0);

    // A pop at full frees the slot the push writes into in the same edge.
    assign w_wr_ok = push & (~w_full | pop);
    assign w_rd_ok = pop & ~w_empty;

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= c_af);
    assign almost_empty = (r_level <= c_ae);
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + PW'(1);
                2'b01:   r_level <= r_level - PW'(1);
                default: r_level <= r_level;
            endcase
            // A fresh error in the same cycle wins over the clear request.
            if (push & ~w_wr_ok) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (pop & ~w_rd_ok) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = r_mem[w_rd_addr];
    assign rd_valid = ~w_empty;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                data_out <= r_mem[w_rd_addr];
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_param_flags.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_param_flags
//  Brief    : Self-checking bench for fifo_param_flags against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_param_flags;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int AF_THRESH = 14;
    localparam int AE_THRESH = 2;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              push;
    logic              pop;
    logic              clr_err;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              underflow;

    fifo_param_flags #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .clr_err      (clr_err),
        .data_in      (data_in),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_dout;
    logic              m_valid;
    logic              m_ovf;
    logic              m_unf;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = m_q.size();
        chk("level", 32'(level), 32'(sz));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("almost_full", 32'(almost_full), 32'(sz >= AF_THRESH));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= AE_THRESH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
        chk("rd_valid", 32'(rd_valid), 32'(sz != 0));
        if (sz != 0) chk("data_out", 32'(data_out), 32'(m_q[0]));
`else
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("data_out", 32'(data_out), 32'(m_dout));
`endif
    endtask

    // One clock: drive at negedge, advance model, check 1 ns after the edge.
    task automatic cyc(input logic p, input logic r, input logic c, input logic [DATA_W-1:0] d);
        bit is_full, is_empty, wr, rd;
        push = p; pop = r; clr_err = c; data_in = d;
        is_full  = (m_q.size() == DEPTH);
        is_empty = (m_q.size() == 0);
        wr = p && (!is_full || r);
        rd = r && !is_empty;
        if (rd) begin
            m_dout  = m_q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (wr) m_q.push_back(d);
        if (p && !wr) m_ovf = 1'b1;
        else if (c)   m_ovf = 1'b0;
        if (r && !rd) m_unf = 1'b1;
        else if (c)   m_unf = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        m_q.delete();
        m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = '0;
        @(negedge clk);
        do_reset();

        // Reset mid-traffic at level 5
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, DATA_W'($urandom));
        chk("level_before_reset", 32'(level), 32'd5);
        do_reset();

        // Fill then drain, plus overflow at full
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, DATA_W'(i));
        cyc(1'b1, 1'b0, 1'b0, 8'hAA);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        // Simultaneous push+pop at full
        cyc(1'b1, 1'b1, 1'b0, 8'h77);
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        // Underflow with same-cycle push
        cyc(1'b1, 1'b1, 1'b0, 8'h55);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 8'h12);
        // Clear and a new error in the same cycle: error wins
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);

        // Wrap test: level 3 then interleaved push/pop
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, DATA_W'($urandom));
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, DATA_W'($urandom));

        // Random traffic with shifting bias to visit full and empty
        for (int seg = 0; seg < 10; seg++) begin
            int pw, pr;
            pw = (seg % 2 == 0) ? 75 : 25;
            pr = 100 - pw;
            for (int i = 0; i < 150; i++) begin
                cyc(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
                    1'($urandom_range(0, 99) < 5), DATA_W'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
